// File: rtl/prog_delay_pkg.sv
// Shared types and helpers for the programmable delay line.
package prog_delay_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Bits needed to index n distinct values, never less than 1.
    function automatic int unsigned width_for(input int unsigned n);
        return (n <= 1) ? 1 : unsigned'($clog2(n));
    endfunction

    // Legal delays are 1..max_d; out-of-range requests saturate.
    function automatic int unsigned clamp_delay(input int unsigned d, input int unsigned max_d);
        if (d == 0) begin
            return 1;
        end
        if (d > max_d) begin
            return max_d;
        end
        return d;
    endfunction

endpackage

// File: rtl/dl_ram.sv
// Simple dual-port sample RAM: one write port, two registered read ports.
module dl_ram
    import prog_delay_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 128,
    localparam int unsigned AW    = width_for(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_a_en,
    input  logic [AW-1:0]    rd_a_addr,
    output logic [WIDTH-1:0] rd_a_data,
    input  logic             rd_b_en,
    input  logic [AW-1:0]    rd_b_addr,
    output logic [WIDTH-1:0] rd_b_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_a_d, rd_a_q;
    logic [WIDTH-1:0] rd_b_d, rd_b_q;

    // Port A is write-first so a zero-offset read returns the sample being written.
    always_comb begin
        rd_a_d = rd_a_q;
        rd_b_d = rd_b_q;
        if (rd_a_en) begin
            rd_a_d = (we && (waddr == rd_a_addr)) ? wdata : mem_q[rd_a_addr];
        end
        if (rd_b_en) begin
            rd_b_d = mem_q[rd_b_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Only the read registers are reset; the array is cleared by the owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
        end
    end

    assign rd_a_data = rd_a_q;
    assign rd_b_data = rd_b_q;

endmodule

// File: rtl/prog_delay_line.sv
// Runtime-programmable delay line on a circular buffer, with a random-access tap port.
module prog_delay_line
    import prog_delay_pkg::*;
#(
    parameter  int unsigned WIDTH         = 16,
    parameter  int unsigned MAX_DEPTH     = 128,
    parameter  int unsigned DEFAULT_DELAY = 101,
    localparam int unsigned DW            = width_for(MAX_DEPTH + 1),
    localparam int unsigned AW            = width_for(MAX_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             delay_ld,
    input  logic [DW-1:0]    delay_in,
    input  logic [AW-1:0]    tap_addr,
    output logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_stb,
    output logic             dout_valid,
    output logic [WIDTH-1:0] tap_dout
);

    localparam logic [DW-1:0] D_RESET   = DW'(clamp_delay(DEFAULT_DELAY, MAX_DEPTH));
    localparam logic [DW-1:0] MAX_D     = DW'(MAX_DEPTH);
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(MAX_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MAX_DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic [DW-1:0] fill_q, fill_d;
    logic [DW-1:0] delay_q, delay_d;
    logic          ready_q, ready_d;
    logic          stb_q, stb_d;
    logic          valid_q, valid_d;

    logic             accept;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [AW:0]      rd_diff;
    logic [AW:0]      tap_off;
    logic [AW:0]      tap_diff;
    logic [AW-1:0]    rd_addr;
    logic [AW-1:0]    tap_rd_addr;

    // Next-state: clear sweep, write pointer, delay/fill bookkeeping.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        clr_ptr_d = clr_ptr_q;
        fill_d    = fill_q;
        delay_d   = delay_q;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;
        mem_wdata = din;
        accept    = (state_q == RUN) && en;

        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = '0;
            clr_ptr_d = clr_ptr_q + AW'(1);
            if (clr_ptr_q == LAST_ADDR) begin
                state_d   = RUN;
                clr_ptr_d = '0;
            end
        end else if (en) begin
            mem_we   = 1'b1;
            wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + AW'(1);
        end

        // A same-edge load takes effect for that edge's read and restarts the fill count.
        if (delay_ld) begin
            delay_d = DW'(clamp_delay(32'(delay_in), MAX_DEPTH));
            fill_d  = accept ? DW'(1) : '0;
        end else if (accept && (fill_q != MAX_D)) begin
            fill_d = fill_q + DW'(1);
        end

        valid_d = (fill_d >= delay_d);
        stb_d   = accept;
        ready_d = (state_d == RUN);

        if (rst) begin
            mem_we = 1'b0;
        end
    end

    // Modular address arithmetic in AW+1 bits, folding back by MAX_DEPTH on borrow.
    always_comb begin
        rd_diff = {1'b0, wr_ptr_q} - {1'b0, AW'(delay_d - DW'(1))};
        if (rd_diff[AW]) begin
            rd_diff = rd_diff + DEPTH_W;
        end
        rd_addr = rd_diff[AW-1:0];

        tap_off = {1'b0, tap_addr};
        if (tap_off >= DEPTH_W) begin
            tap_off = tap_off - DEPTH_W;
        end
        tap_off  = tap_off + (AW+1)'(1);
        tap_diff = {1'b0, wr_ptr_q} - tap_off;
        if (tap_diff[AW]) begin
            tap_diff = tap_diff + DEPTH_W;
        end
        tap_rd_addr = tap_diff[AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            wr_ptr_q  <= '0;
            clr_ptr_q <= '0;
            fill_q    <= '0;
            delay_q   <= D_RESET;
            ready_q   <= 1'b0;
            stb_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            clr_ptr_q <= clr_ptr_d;
            fill_q    <= fill_d;
            delay_q   <= delay_d;
            ready_q   <= ready_d;
            stb_q     <= stb_d;
            valid_q   <= valid_d;
        end
    end

    dl_ram #(
        .WIDTH (WIDTH),
        .DEPTH (MAX_DEPTH)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .we        (mem_we),
        .waddr     (mem_waddr),
        .wdata     (mem_wdata),
        .rd_a_en   (accept),
        .rd_a_addr (rd_addr),
        .rd_a_data (dout),
        .rd_b_en   (state_q == RUN),
        .rd_b_addr (tap_rd_addr),
        .rd_b_data (tap_dout)
    );

    assign ready      = ready_q;
    assign dout_stb   = stb_q;
    assign dout_valid = valid_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed bench: a 128-deep line (default delay, reload, clamp, taps) and an 8-deep line (clear, wrap, mid-run reset).
module tb_prog_delay_line;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 128-deep instance
    logic        a_rst = 1'b1, a_en = 1'b0, a_delay_ld = 1'b0;
    logic [15:0] a_din = '0;
    logic [7:0]  a_delay_in = '0;
    logic [6:0]  a_tap_addr = '0;
    logic        a_ready, a_stb, a_valid;
    logic [15:0] a_dout, a_tap;

    // 8-deep instance
    logic        b_rst = 1'b1, b_en = 1'b0, b_delay_ld = 1'b0;
    logic [15:0] b_din = '0;
    logic [3:0]  b_delay_in = '0;
    logic [2:0]  b_tap_addr = '0;
    logic        b_ready, b_stb, b_valid;
    logic [15:0] b_dout, b_tap;

    prog_delay_line #(.WIDTH(16), .MAX_DEPTH(128), .DEFAULT_DELAY(101)) dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .din(a_din), .delay_ld(a_delay_ld),
        .delay_in(a_delay_in), .tap_addr(a_tap_addr), .ready(a_ready), .dout(a_dout),
        .dout_stb(a_stb), .dout_valid(a_valid), .tap_dout(a_tap)
    );

    prog_delay_line #(.WIDTH(16), .MAX_DEPTH(8), .DEFAULT_DELAY(8)) dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .din(b_din), .delay_ld(b_delay_ld),
        .delay_in(b_delay_in), .tap_addr(b_tap_addr), .ready(b_ready), .dout(b_dout),
        .dout_stb(b_stb), .dout_valid(b_valid), .tap_dout(b_tap)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] din;
        logic [2:0]  tap;
        logic        e_ready;
        logic        e_stb;
        logic        e_valid;
        logic [15:0] e_dout;
        logic [15:0] e_tap;
    } vec_t;

    localparam int NVEC = 56;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_accept(input int v);
        a_en  = 1'b1;
        a_din = 16'(v);
        tick();
        a_en  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // ---------------- 128-deep line ----------------
        tick();
        a_rst = 1'b0;
        check("a_rst ready", 32'(a_ready), 32'd0);
        check("a_rst dout",  32'(a_dout),  32'd0);
        check("a_rst stb",   32'(a_stb),   32'd0);
        check("a_rst valid", 32'(a_valid), 32'd0);
        check("a_rst tap",   32'(a_tap),   32'd0);

        begin
            int n = 0;
            while (!a_ready && n < 300) begin
                tick();
                n++;
            end
            check("a_clear_len", 32'(n), 32'd128);
        end
        check("a_clear tap", 32'(a_tap), 32'd0);

        for (int n = 1; n <= 150; n++) begin
            a_accept(n);
            if (n == 1) begin
                check("a_acc1 stb",   32'(a_stb),   32'd1);
                check("a_acc1 dout",  32'(a_dout),  32'd0);
                check("a_acc1 valid", 32'(a_valid), 32'd0);
            end
            if (n == 100) begin
                check("a_acc100 dout",  32'(a_dout),  32'd0);
                check("a_acc100 valid", 32'(a_valid), 32'd0);
            end
            if (n == 101) begin
                check("a_acc101 dout",  32'(a_dout),  32'd1);
                check("a_acc101 valid", 32'(a_valid), 32'd1);
            end
            if (n == 150) begin
                check("a_acc150 dout", 32'(a_dout), 32'd50);
            end
        end

        tick();
        check("a_gap stb",  32'(a_stb),  32'd0);
        check("a_gap dout", 32'(a_dout), 32'd50);

        a_tap_addr = 7'd0;
        tick();
        check("a_tap k0", 32'(a_tap), 32'd150);
        a_tap_addr = 7'd3;
        tick();
        check("a_tap k3", 32'(a_tap), 32'd147);
        tick();
        check("a_tap k3 gap", 32'(a_tap), 32'd147);
        a_tap_addr = 7'd127;
        tick();
        check("a_tap k127", 32'(a_tap), 32'd23);

        for (int n = 151; n <= 300; n++) begin
            a_accept(n);
        end
        check("a_acc300 dout", 32'(a_dout), 32'd200);

        // Reload to 5 on the same edge as accept 301.
        a_delay_ld = 1'b1;
        a_delay_in = 8'd5;
        a_accept(301);
        a_delay_ld = 1'b0;
        check("a_ld5 dout",  32'(a_dout),  32'd297);
        check("a_ld5 valid", 32'(a_valid), 32'd0);
        for (int n = 302; n <= 305; n++) begin
            a_accept(n);
            if (n == 304) begin
                check("a_acc304 valid", 32'(a_valid), 32'd0);
                check("a_acc304 dout",  32'(a_dout),  32'd300);
            end
        end
        check("a_acc305 valid", 32'(a_valid), 32'd1);
        check("a_acc305 dout",  32'(a_dout),  32'd301);

        // Delay 0 clamps to 1; load alone clears valid and keeps dout.
        a_delay_ld = 1'b1;
        a_delay_in = 8'd0;
        tick();
        a_delay_ld = 1'b0;
        check("a_ld0 valid", 32'(a_valid), 32'd0);
        check("a_ld0 stb",   32'(a_stb),   32'd0);
        check("a_ld0 dout",  32'(a_dout),  32'd301);
        a_accept(16'h1234);
        check("a_d1 dout",  32'(a_dout),  32'h1234);
        check("a_d1 valid", 32'(a_valid), 32'd1);

        // Delay 200 clamps to 128: accept 307 reads sample 180.
        a_delay_ld = 1'b1;
        a_delay_in = 8'd200;
        a_accept(307);
        a_delay_ld = 1'b0;
        check("a_ld200 dout",  32'(a_dout),  32'd180);
        check("a_ld200 valid", 32'(a_valid), 32'd0);
        for (int n = 308; n <= 434; n++) begin
            a_accept(n);
            if (n == 433) begin
                check("a_acc433 valid", 32'(a_valid), 32'd0);
                check("a_acc433 dout",  32'(a_dout),  32'h1234);
            end
        end
        check("a_acc434 valid", 32'(a_valid), 32'd1);
        check("a_acc434 dout",  32'(a_dout),  32'd307);

        // ---------------- 8-deep line: table ----------------
        for (int r = 0; r < NVEC; r++) begin
            vec_t v;
            v = '{default: '0};
            if (r == 0 || r == 39) begin
                v.rst = 1'b1;
                v.en  = 1'b1;
                v.din = (r == 0) ? 16'hAAAA : 16'd31;
            end else if ((r >= 1 && r <= 8) || (r >= 40 && r <= 47)) begin
                v.en      = 1'b1;
                v.din     = 16'(16'h100 + r);
                v.e_ready = (r == 8 || r == 47);
            end else if (r >= 9 && r <= 38) begin
                int n;
                int k;
                n = r - 8;
                k = n % 8;
                v.en      = 1'b1;
                v.din     = 16'(n);
                v.tap     = 3'(k);
                v.e_ready = 1'b1;
                v.e_stb   = 1'b1;
                v.e_valid = (n >= 8);
                v.e_dout  = (n >= 8) ? 16'(n - 7) : 16'd0;
                v.e_tap   = (n - 1 - k >= 1) ? 16'(n - 1 - k) : 16'd0;
            end else begin
                int m;
                m = r - 47;
                v.en      = 1'b1;
                v.din     = 16'(100 + m);
                v.e_ready = 1'b1;
                v.e_stb   = 1'b1;
                v.e_valid = (m == 8);
                v.e_dout  = (m == 8) ? 16'd101 : 16'd0;
                v.e_tap   = (m >= 2) ? 16'(100 + m - 1) : 16'd0;
            end
            vecs[r] = v;
        end

        for (int r = 0; r < NVEC; r++) begin
            b_rst      = vecs[r].rst;
            b_en       = vecs[r].en;
            b_din      = vecs[r].din;
            b_tap_addr = vecs[r].tap;
            tick();
            check($sformatf("b[%0d] ready", r), 32'(b_ready), 32'(vecs[r].e_ready));
            check($sformatf("b[%0d] stb",   r), 32'(b_stb),   32'(vecs[r].e_stb));
            check($sformatf("b[%0d] valid", r), 32'(b_valid), 32'(vecs[r].e_valid));
            check($sformatf("b[%0d] dout",  r), 32'(b_dout),  32'(vecs[r].e_dout));
            check($sformatf("b[%0d] tap",   r), 32'(b_tap),   32'(vecs[r].e_tap));
        end
        b_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_delay_line.md
Name: prog_delay_line

Overview:
- Runtime-programmable, parametrised successor to the fixed shift-register delay line used in the LMS datapath.
- Stores samples in a circular buffer (inferred RAM) rather than a register chain.
- Delay is loadable from 1..MAX_DEPTH at run time; outputs carry a valid flag and an auxiliary random-access tap read port for LMS coefficient update.
- Sits between the sample source and the adaptive filter or reference-path alignment.

Parameters:
- WIDTH, 16, sample width in bits.
- MAX_DEPTH, 128, buffer size in samples and the largest legal delay. Must be ≥2.
- DEFAULT_DELAY, 101, delay in effect after reset. Clamped to 1..MAX_DEPTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  sample strobe; din is accepted on the clk edge where en=1 and ready=1.
- din  in  WIDTH  input sample.
- delay_ld  in  1  load strobe for delay_in.
- delay_in  in  DW  requested delay, where DW = $clog2(MAX_DEPTH+1).
- tap_addr  in  AW  tap index k, where AW = $clog2(MAX_DEPTH); k=0 is the newest sample.
- ready  out  1  high once memory clear is complete.
- dout  out  WIDTH  delayed sample.
- dout_stb  out  1  one-clk pulse; dout updated this cycle.
- dout_valid  out  1  buffer holds at least D samples since the last delay load.
- tap_dout  out  WIDTH  sample at tap k, with 1-clk read latency.

Behaviour:
- Reset: the design is clocked by clk and reset by rst; reset is synchronous and active-high.
  - On the rst edge: state=CLEAR, wr_ptr=0, clr_ptr=0, fill=0, D=clamp(DEFAULT_DELAY).
  - All outputs reset to 0, including ready.
  - rst mid-operation aborts everything and restarts CLEAR from address 0.
- FSM, CLEAR state:
  - Writes 0 to mem[clr_ptr] each clk and increments clr_ptr.
  - After the write to address MAX_DEPTH-1, moves to RUN; ready=1 from the next cycle.
  - CLEAR lasts exactly MAX_DEPTH cycles. en is ignored (sample dropped, no dout_stb).
- FSM, RUN state: stays in RUN until rst.
- Write path (RUN, en=1): mem[wr_ptr] <= din; wr_ptr <= (wr_ptr==MAX_DEPTH-1) ? 0 : wr_ptr+1.
- Delay semantics: number accepted samples n = 1, 2, …. After the edge accepting sample n:
  - dout = din of sample n-D+1.
  - Samples older than the last clear read as 0.
  - D=MAX_DEPTH reproduces the legacy fixed-length line with LENGTH=MAX_DEPTH.
- Read path: on an accept edge, dout <= (D==1) ? din : mem[(wr_ptr-(D-1)) mod MAX_DEPTH]. Modular subtraction is done in AW+1 bits, adding MAX_DEPTH on borrow. dout_stb <= 1 on accept edges, 0 otherwise. dout holds between accepts.
- Delay load (delay_ld=1, any state):
  - D <= clamp(delay_in): 0 becomes 1, values above MAX_DEPTH become MAX_DEPTH.
  - fill <= 0, dout_valid <= 0.
  - Buffer contents are kept.
  - If en accepts on the same edge: the new D is used for that read, and fill <= 1.
- Fill/valid:
  - fill increments on each accept, saturating at MAX_DEPTH.
  - dout_valid <= (fill_next ≥ D), updated on every edge.
  - After reset, D=DEFAULT_DELAY and dout_valid rises on accept number D.
- Tap port: every clk in RUN, tap_dout <= mem[(wr_ptr-1-k) mod MAX_DEPTH], using wr_ptr before any same-edge write. This is independent of en.
  - k ≥ MAX_DEPTH wraps modulo MAX_DEPTH.
  - In CLEAR, tap_dout=0.
- Wrap-around: the pointer wraps seamlessly. No full/empty condition exists; the oldest sample is always overwritten.

Decomposition:
- Package prog_delay_pkg: state enum {CLEAR, RUN}, a clog2-based width helper, and a clamp function for delay.
- One sub-module, dl_ram: simple dual-port RAM (1 write, 2 registered reads) of WIDTH×MAX_DEPTH, with no reset on the array.
- Top level holds the FSM, pointers, fill counter and read-address arithmetic.

Test Plan:
- Reset/clear: MAX_DEPTH=8, rst 1 cycle, then en=1 continuously → ready=0 for 8 cycles then 1. The first 8 en cycles are dropped. tap_dout=0 for all k.
- Default delay: MAX_DEPTH=128, DEFAULT_DELAY=101, din=1,2,3… each accept → dout=0 until accept 101, where dout=1 and dout_valid=1. Accept 150 gives dout=50.
- Delay=1 and clamp: delay_in=0 then din=0x1234 → dout=0x1234 on the same accept, dout_valid=1. delay_in=200 (MAX_DEPTH=128) → D=128.
- Runtime reload with simultaneous en: after 300 samples, delay_ld=1 with delay_in=5 on an accept edge of sample 301 → dout=297, dout_valid=0. dout_valid=1 at accept 305 with dout=301.
- Tap port: after samples 1..20, tap_addr=0 → tap_dout=20 next clk. tap_addr=3 → 17. en gaps do not change tap_dout.
- Mid-run reset and wrap: MAX_DEPTH=8, D=8, 30 samples (pointer wraps 3×) → dout correct across wraps. rst at sample 31 → all outputs 0, clear repeats, post-clear dout=0 until 8 new samples.
